// File: rtl/seq_mlp_argmax_engine.sv
// Time-multiplexed 2-layer MLP classifier: one shared signed MAC, loadable
// coefficients, QReLU hidden layer, linear output layer and running argmax.
module seq_mlp_argmax_engine #(
    parameter int unsigned N_IN      = 9,
    parameter int unsigned IN_W      = 4,
    parameter int unsigned N_HID     = 3,
    parameter int unsigned N_OUT     = 2,
    parameter int unsigned W_W       = 4,
    parameter int unsigned HID_W     = 4,
    parameter int unsigned QRELU_LSB = 3,
    parameter int unsigned BIAS_SH0  = 4,
    parameter int unsigned BIAS_SH1  = 2,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned OUT_W     = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1,
    localparam int unsigned DEPTH    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1),
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [W_W-1:0]   wr_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*IN_W-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    busy
);

    localparam int unsigned B1     = N_HID * (N_IN + 1);
    localparam int unsigned OPD_W  = ((IN_W > HID_W) ? IN_W : HID_W) + 1;
    localparam int unsigned PROD_W = W_W + OPD_W;
    localparam int unsigned MAXN   = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                                    : ((N_HID > N_OUT) ? N_HID : N_OUT);
    localparam int unsigned CNT_W  = $clog2(MAXN + 1);
    localparam int unsigned SAT_SH = QRELU_LSB + HID_W;

    typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

    state_t                    state;
    logic signed [W_W-1:0]     coef [DEPTH];
    logic [N_IN*IN_W-1:0]      sample;
    logic [N_HID*HID_W-1:0]    hid;
    logic [CNT_W-1:0]          t;
    logic [CNT_W-1:0]          n;
    logic signed [ACC_W-1:0]   acc;
    logic [OUT_W-1:0]          best_class;
    logic signed [ACC_W-1:0]   best_score;

    logic [AW-1:0]             wgt_addr_c;
    logic [AW-1:0]             bias_addr_c;
    logic signed [OPD_W-1:0]   opd_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   bias_c;
    logic signed [ACC_W-1:0]   sum_c;
    logic [HID_W-1:0]          qrelu_c;
    logic                      last_c;

    // Coefficient addressing and operand selection for the shared MAC
    always_comb begin
        wgt_addr_c  = AW'(32'(n) * N_IN + 32'(t));
        bias_addr_c = AW'(N_HID * N_IN + 32'(n));
        opd_c       = $signed(OPD_W'(sample[32'(t) * IN_W +: IN_W]));
        last_c      = (t == CNT_W'(N_IN - 1));
        if (state == L1) begin
            wgt_addr_c  = AW'(B1 + 32'(n) * N_HID + 32'(t));
            bias_addr_c = AW'(B1 + N_OUT * N_HID + 32'(n));
            opd_c       = $signed(OPD_W'(hid[32'(t) * HID_W +: HID_W]));
            last_c      = (t == CNT_W'(N_HID - 1));
        end
        prod_c = coef[wgt_addr_c] * opd_c;
        bias_c = ACC_W'(coef[bias_addr_c]) <<< ((state == L1) ? BIAS_SH1 : BIAS_SH0);
        sum_c  = ((t == '0) ? bias_c : acc) + ACC_W'(prod_c);
    end

    // QReLU: clamp negatives to zero, saturate anything above the kept window
    always_comb begin
        qrelu_c = '0;
        if (!sum_c[ACC_W-1]) begin
            if ((sum_c >>> SAT_SH) != '0) qrelu_c = '1;
            else                          qrelu_c = sum_c[QRELU_LSB +: HID_W];
        end
    end

    // Coefficient store; only writable while no inference is running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) coef[k] <= '0;
        end else if (wr_en && (state == IDLE || state == DONE) && 32'(wr_addr) < DEPTH) begin
            coef[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_score  <= '0;
            busy       <= 1'b0;
            sample     <= '0;
            hid        <= '0;
            t          <= '0;
            n          <= '0;
            acc        <= '0;
            best_class <= '0;
            best_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sample   <= in_data;
                        t        <= '0;
                        n        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= L0;
                    end
                end
                L0: begin
                    acc <= sum_c;
                    if (last_c) begin
                        hid[32'(n) * HID_W +: HID_W] <= qrelu_c;
                        t <= '0;
                        if (n == CNT_W'(N_HID - 1)) begin
                            n     <= '0;
                            state <= L1;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                L1: begin
                    acc <= sum_c;
                    if (last_c) begin
                        // strict '>' keeps the lower index on ties
                        if (n == '0 || sum_c > best_score) begin
                            best_score <= sum_c;
                            best_class <= OUT_W'(n);
                        end
                        t <= '0;
                        if (n == CNT_W'(N_OUT - 1)) begin
                            n     <= '0;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                DONE: begin
                    // first DONE cycle publishes the argmax, then waits for the consumer
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_class <= best_class;
                        out_score <= best_score;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mlp_argmax_engine.sv
// Randomized and directed bench for seq_mlp_argmax_engine against an
// array-based reference model of the two-layer MLP plus argmax.
module tb_seq_mlp_argmax_engine;

    localparam int N_IN = 9, IN_W = 4, N_HID = 3, N_OUT = 2, W_W = 4;
    localparam int HID_W = 4, QRELU_LSB = 3, BIAS_SH0 = 4, BIAS_SH1 = 2, ACC_W = 12;
    localparam int OUT_W = 1;
    localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
    localparam int AW = 6;
    localparam int B1 = N_HID * (N_IN + 1);
    localparam int LATENCY = N_HID * N_IN + N_OUT * N_HID + 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    wr_en = 1'b0;
    logic [AW-1:0]           wr_addr = '0;
    logic signed [W_W-1:0]   wr_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [N_IN*IN_W-1:0]    in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [OUT_W-1:0]        out_class;
    logic signed [ACC_W-1:0] out_score;
    logic                    busy;

    seq_mlp_argmax_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mdl_coef [DEPTH];
    int mdl_x [N_IN];
    int exp_class;
    int exp_score;

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Reference: straightforward integer evaluation of the network
    task automatic model_run();
        int acc;
        int hidv [N_HID];
        int best;
        int bcls;
        for (int h = 0; h < N_HID; h++) begin
            acc = mdl_coef[N_HID * N_IN + h] * (1 << BIAS_SH0);
            for (int i = 0; i < N_IN; i++) acc += mdl_coef[h * N_IN + i] * mdl_x[i];
            if (acc < 0)                                   hidv[h] = 0;
            else if ((acc >>> QRELU_LSB) > 2**HID_W - 1)   hidv[h] = 2**HID_W - 1;
            else                                           hidv[h] = acc >>> QRELU_LSB;
        end
        best = 0;
        bcls = 0;
        for (int o = 0; o < N_OUT; o++) begin
            acc = mdl_coef[B1 + N_OUT * N_HID + o] * (1 << BIAS_SH1);
            for (int h = 0; h < N_HID; h++) acc += mdl_coef[B1 + o * N_HID + h] * hidv[h];
            if (o == 0 || acc > best) begin
                best = acc;
                bcls = o;
            end
        end
        exp_class = bcls;
        exp_score = best;
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = W_W'(val);
        @(negedge clk);
        wr_en = 1'b0;
        if (addr < DEPTH) mdl_coef[addr] = val;
    endtask

    task automatic load_default();
        int l0 [N_HID*N_IN];
        int c1 [11];
        l0 = '{2, 1, 2, 0, 1, 2, 0, 1, 2,
               1, 0, 2, 1, 0, 2, 2, 0, 1,
               0, -2, -2, 0, 2, -2, 2, -2, -2};
        c1 = '{-1, -1, 2, -4, -4, 4, 2, 4, -4, 4, -1};
        for (int k = 0; k < N_HID * N_IN; k++) write_coef(k, l0[k]);
        for (int k = 0; k < 11; k++) write_coef(N_HID * N_IN + k, c1[k]);
    endtask

    task automatic set_all_x(input int v);
        for (int i = 0; i < N_IN; i++) mdl_x[i] = v;
    endtask

    // One inference: accept, count latency, compare, optionally stall the consumer
    task automatic run_infer(input string tag, input int hold, input bit wr_at_accept,
                             input int wa, input int wv, input bit busy_wr);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, int'(in_ready), 1);
        for (int i = 0; i < N_IN; i++) in_data[i*IN_W +: IN_W] = IN_W'(mdl_x[i]);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        if (wr_at_accept) begin
            wr_en   = 1'b1;
            wr_addr = AW'(wa);
            wr_data = W_W'(wv);
            mdl_coef[wa] = wv;
        end
        model_run();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        n = 0;
        while (!out_valid && n < 100) begin
            if (busy_wr && n == 5) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 4'sd7;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        wr_en = 1'b0;
        check({tag, "_latency"}, n, LATENCY);
        check({tag, "_class"}, int'(out_class), exp_class);
        check({tag, "_score"}, int'(out_score), exp_score);
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, int'(out_valid), 1);
                check({tag, "_hold_class"}, int'(out_class), exp_class);
                check({tag, "_hold_score"}, int'(out_score), exp_score);
                check({tag, "_hold_in_ready"}, int'(in_ready), 0);
                check({tag, "_hold_busy"}, int'(busy), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_release_valid"}, int'(out_valid), 0);
        check({tag, "_release_in_ready"}, int'(in_ready), 1);
        check({tag, "_release_busy"}, int'(busy), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mdl_coef[k] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_class", int'(out_class), 0);
        check("rst_score", int'(out_score), 0);
        check("rst_busy", int'(busy), 0);

        load_default();
        set_all_x(0);
        run_infer("zero", 0, 1'b0, 0, 0, 1'b0);
        check("zero_spec_score", int'(out_score), 32);

        set_all_x(15);
        run_infer("max_hold", 10, 1'b0, 0, 0, 1'b0);
        check("max_spec_class", int'(out_class), 1);
        check("max_spec_score", int'(out_score), 82);

        run_infer("busy_wr", 0, 1'b0, 0, 0, 1'b1);
        run_infer("after_busy_wr", 0, 1'b0, 0, 0, 1'b0);
        check("after_busy_wr_score", int'(out_score), 82);

        for (int k = 0; k < DEPTH; k++) write_coef(k, 0);
        write_coef(DEPTH - 2, 3);
        write_coef(DEPTH - 1, 3);
        set_all_x(9);
        run_infer("tie", 0, 1'b0, 0, 0, 1'b0);
        check("tie_spec_class", int'(out_class), 0);
        check("tie_spec_score", int'(out_score), 12);

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < DEPTH; k++) write_coef(k, int'($urandom_range(15, 0)) - 8);
            write_coef(DEPTH + int'($urandom_range(63 - DEPTH, 0)), 7);
            for (int i = 0; i < N_IN; i++) mdl_x[i] = int'($urandom_range(15, 0));
            run_infer($sformatf("rand%0d", it), int'($urandom_range(3, 0)),
                      1'($urandom_range(1, 0)), int'($urandom_range(DEPTH - 1, 0)),
                      int'($urandom_range(15, 0)) - 8, 1'b0);
        end

        // Abort mid-inference with reset
        load_default();
        set_all_x(15);
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) in_data[i*IN_W +: IN_W] = IN_W'(mdl_x[i]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_score", int'(out_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) mdl_coef[k] = 0;
        for (int i = 0; i < N_IN; i++) mdl_x[i] = int'($urandom_range(15, 0));
        run_infer("post_abort", 0, 1'b0, 0, 0, 1'b0);
        check("post_abort_spec_score", int'(out_score), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
